aud_recorder: RTL

AUD_RECORDER -- requirements
Module: aud_recorder

---
 rtl/aud_recorder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/aud_recorder.sv
// Audio recorder: captures the left channel of an I2S ADC stream into
// consecutive storage words under start / pause / resume / stop control.
module aud_recorder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_done
);
    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX  = '1;

    typedef enum logic [2:0] {IDLE, WAIT, SHIFT, STORE, PAUSED} state_t;

    state_t            state;
    logic              lrc_prev;
    logic              pause_pend;
    logic              lfs;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [ADDR_W-1:0] ptr;

    // Left-frame start: LR clock falling from right to left channel.
    assign lfs       = lrc_prev & ~i_lrc;
    assign o_address = ptr;

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            lrc_prev   <= 1'b0;
            pause_pend <= 1'b0;
            bit_cnt    <= '0;
            // NOTE: the shift register and data output are reset as well so a
            // word cut short by reset can never leak out as a later sample.
            shift_reg  <= '0;
            ptr        <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge values of state, counter and pointer.
            lrc_prev <= i_lrc;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start && !i_pause && !i_stop) begin
                        state <= WAIT;
                        ptr   <= '0;
                    end
                end

                WAIT: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end else if (i_pause) begin
                        state <= PAUSED;
                    end else if (lfs) begin
                        // The bit at the LFS edge belongs to the previous slot.
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end

                SHIFT: begin
                    if (i_stop) begin
                        state      <= IDLE;
                        o_done     <= 1'b1;
                        pause_pend <= 1'b0;
                    end else begin
                        shift_reg <= {shift_reg[DATA_W-2:0], i_data};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (i_pause) pause_pend <= 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                            o_data  <= {shift_reg[DATA_W-2:0], i_data};
                            o_valid <= 1'b1;
                            state   <= STORE;
                        end
                    end
                end

                STORE: begin
                    if (ptr == PTR_MAX) begin
                        state      <= IDLE;
                        o_done     <= 1'b1;
                        pause_pend <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                        if (i_stop) begin
                            state      <= IDLE;
                            o_done     <= 1'b1;
                            pause_pend <= 1'b0;
                        end else if (pause_pend || i_pause) begin
                            state      <= PAUSED;
                            pause_pend <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                PAUSED: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end else if (i_start && !i_pause) begin
                        state <= WAIT;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
